esm_slot_selector: RTL and testbench

- Control core of the instruction-reordering buffer (ESM).
- Each cycle the wrapper does two things at the slot this block names on buffer_index: it issues the instruction held in that slot and overwrites the slot with the incoming instruction.
- This block keeps per-slot metadata (valid, age, register fields) and picks the slot so that the issued stream respects register dependencies and, where possible, avoids reading the register written by the previously issued instruction.

---
 rtl/esm_slot_selector.sv | 84 ++++++++
 tb/tb_esm_slot_selector.sv | 80 ++++++++
 2 files changed

// File: rtl/esm_slot_selector.sv
// esm_slot_selector: picks the buffer slot to issue/refill, honouring register hazards and avoiding last_rd reads
module esm_slot_selector #(
  parameter int Instr_word_size = 32,
  parameter int regnum = 32,
  parameter int bs = 16,
  localparam int RW = $clog2(regnum),
  localparam int IW = $clog2(bs),
  localparam int AW = IW + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [Instr_word_size-1:0] Instr_in,
  input  logic                       ALUSrc,
  input  logic                       RegWrite,
  output logic [IW-1:0]              buffer_index
);
  logic [bs-1:0] valid, rd_w, rs2_r, rdy;
  logic [AW-1:0] age [bs];
  logic [RW-1:0] rd [bs];
  logic [RW-1:0] rs1 [bs];
  logic [RW-1:0] rs2 [bs];
  logic [RW-1:0] last_rd;
  logic last_w, inv_hit, ok_hit;
  logic [IW-1:0] inv_idx, ok_idx, old_idx;
  function automatic logic older(input logic [AW-1:0] aa, input logic [IW-1:0] a,
                                 input logic [AW-1:0] ab, input logic [IW-1:0] b);
    return aa > ab || (aa == ab && a < b);
  endfunction
  always_comb begin
    rdy = '1;
    for (int s = 0; s < bs; s++)
      for (int o = 0; o < bs; o++)
        if (o != s && older(age[o], IW'(o), age[s], IW'(s)) &&
            ((rd_w[o] && (rd[o] == rs1[s] || (rs2_r[s] && rd[o] == rs2[s]))) ||
             (rd_w[o] && rd_w[s] && rd[o] == rd[s]) ||
             (rd_w[s] && (rd[s] == rs1[o] || (rs2_r[o] && rd[s] == rs2[o])))))
          rdy[s] = 1'b0;
  end
  // ascending scan plus index tie-break keeps the lowest index on equal ages
  always_comb begin
    inv_hit = 1'b0;
    inv_idx = '0;
    ok_hit = 1'b0;
    ok_idx = '0;
    old_idx = '0;
    for (int i = 0; i < bs; i++) begin
      if (!valid[i] && !inv_hit) begin
        inv_hit = 1'b1;
        inv_idx = IW'(i);
      end
      if (older(age[i], IW'(i), age[old_idx], old_idx))
        old_idx = IW'(i);
      if (rdy[i] && !(last_w && (rs1[i] == last_rd || (rs2_r[i] && rs2[i] == last_rd))) &&
          (!ok_hit || older(age[i], IW'(i), age[ok_idx], ok_idx))) begin
        ok_hit = 1'b1;
        ok_idx = IW'(i);
      end
    end
    buffer_index = inv_hit ? inv_idx : ok_hit ? ok_idx : old_idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      last_w <= 1'b0;
      last_rd <= '0;
      for (int i = 0; i < bs; i++)
        age[i] <= '0;
    end else begin
      last_w <= valid[buffer_index] && rd_w[buffer_index];
      last_rd <= rd[buffer_index];
      for (int i = 0; i < bs; i++)
        if (IW'(i) == buffer_index) begin
          valid[i] <= Instr_in != '0;
          age[i] <= '0;
          rd[i] <= Instr_in[11:7];
          rs1[i] <= Instr_in[19:15];
          rs2[i] <= Instr_in[24:20];
          rd_w[i] <= RegWrite && Instr_in[11:7] != '0;
          rs2_r[i] <= !ALUSrc;
        end else
          age[i] <= valid[i] ? age[i] + AW'(age[i] != '1) : '0;
    end
  end
endmodule

// File: tb/tb_esm_slot_selector.sv
// tb_esm_slot_selector: directed vectors for slot selection, hazards, bubbles and reset
module tb_esm_slot_selector;
  logic clk = 0, rst = 1, ALUSrc = 0, RegWrite = 0;
  logic [31:0] Instr_in = '0;
  logic [3:0] buffer_index;
  int n_chk = 0, n_err = 0;
  esm_slot_selector dut (.clk(clk), .rst(rst), .Instr_in(Instr_in), .ALUSrc(ALUSrc),
                         .RegWrite(RegWrite), .buffer_index(buffer_index));
  always #5 clk = ~clk;
  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return {7'b0, rs2[4:0], rs1[4:0], 3'b0, rd[4:0], 7'h13};
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic [31:0] ins, input logic alu, input logic rw);
    Instr_in = ins;
    ALUSrc = alu;
    RegWrite = rw;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  initial begin
    do_reset();
    chk("reset_idx", buffer_index, 0);
    for (int i = 0; i < 16; i++) begin
      chk("fill", buffer_index, i);
      step(mk(i + 1, 0, 0), 1, 1);
    end
    for (int n = 0; n < 20; n++) begin
      chk("fifo", buffer_index, n % 16);
      step(mk(n % 31 + 1, 0, 0), 1, 1);
    end
    chk("bubble_pre", buffer_index, 4);
    step('0, 1, 1);
    chk("bubble_return", buffer_index, 4);
    step(mk(30, 0, 0), 1, 1);
    chk("bubble_next", buffer_index, 5);
    // stall avoidance: slot2 carries rs2 field 5 but uses an immediate
    do_reset();
    step(mk(5, 1, 2), 0, 1);
    step(mk(6, 5, 3), 0, 1);
    step(mk(7, 4, 5), 1, 1);
    for (int i = 3; i < 16; i++) step(mk(7 + i, 0, 0), 1, 1);
    chk("stall_first", buffer_index, 0);
    step(mk(23, 0, 0), 1, 1);
    chk("stall_skip", buffer_index, 2);
    step(mk(24, 0, 0), 1, 1);
    chk("stall_resume", buffer_index, 1);
    // dependency hold: every candidate reads x3 or is WAW-blocked
    do_reset();
    step(mk(3, 0, 0), 1, 1);
    step(mk(9, 3, 0), 1, 1);
    step(mk(9, 0, 0), 1, 1);
    for (int i = 3; i < 16; i++) step(mk(7 + i, 3, 0), 1, 1);
    chk("dep_first", buffer_index, 0);
    step(mk(23, 3, 0), 1, 1);
    chk("dep_fallback", buffer_index, 1);
    step(mk(24, 0, 0), 1, 1);
    chk("dep_waw_release", buffer_index, 2);
    do_reset();
    chk("midreset_idx", buffer_index, 0);
    for (int i = 0; i < 4; i++) begin
      chk("refill", buffer_index, i);
      step(mk(i + 1, 0, 0), 1, 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
